ddr3_ui_arbiter: RTL and testbench
==================================

// Module: ddr3_ui_arbiter
// PURPOSE
//  Shares the single DDR3 MIG user interface (app_*) between NUM_REQ requesters, e.g. ddr3 test engines or DMA ports.
//  Round-robin command arbiter that issues one BL8 (1 UI word) command per grant.
//  Writes: issues command and write data together. Reads: tags each accepted read with its requester ID and
//  routes returning app_rd_data back to that requester, in order.
// PARAMETERS
//  NUM_REQ       2    number of requesters (2..4)
//  ADDR_W        30   UI address width
//  DATA_W        256  UI data width (one BL8 burst)
//  RD_TAG_DEPTH  32   outstanding-read tag FIFO depth (power of 2)
// PORTS
//  clk                input   1               UI clock (MIG ui_clk)
//  reset_n            input   1               asynchronous, active-low reset
//  req_valid          input   NUM_REQ         per-requester command valid
//  req_rnw            input   NUM_REQ         1 = read, 0 = write
//  req_addr           input   NUM_REQ*ADDR_W  per-requester UI word address (flattened, req 0 in LSBs)
//  req_wdata          input   NUM_REQ*DATA_W  per-requester write data (flattened)
//  req_ready          output  NUM_REQ         one-hot; 1-cycle pulse; request captured
//  rsp_valid          output  NUM_REQ         one-hot; read data valid for that requester
//  rsp_data           output  DATA_W          read data, shared by all requesters
//  rd_outstanding     output  log2(RD_TAG_DEPTH)+1  reads accepted by MIG, not yet returned
//  err_unexpected_rd  output  1               sticky; read data arrived with no tag outstanding
//  app_rdy            input   1               MIG command ready
//  app_en/app_cmd/app_addr        output  1/3/ADDR_W   MIG command
//  app_wdf_rdy        input   1               MIG write data ready
//  app_wdf_wren/app_wdf_end       output  1/1          MIG write data strobe/end
//  app_wdf_data       output  DATA_W          MIG write data
//  app_wdf_mask       output  DATA_W/8        constant 0
//  app_rd_data        input   DATA_W          MIG read data
//  app_rd_data_valid  input   1               MIG read data valid
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0, FSM=IDLE, RR pointer=0, tag FIFO empty, err cleared.
//  Eligible requester i: req_valid[i] & (~req_rnw[i] | tag FIFO not full-after-reservation).
//    A read reserves its tag slot at grant time.
//  FSM IDLE
//    - If any eligible: grant first eligible at or after (last_grant+1) mod NUM_REQ.
//    - Grant cycle: req_ready[i] = 1; capture addr/rnw/wdata.
//    - Next cycle: app_en = 1, app_cmd = 001 (read) or 000 (write), app_addr = captured addr.
//    - Write also: app_wdf_wren = app_wdf_end = 1, app_wdf_data = captured data.
//    - -> ISSUE.
//  FSM ISSUE
//    - Hold app_en until sampled with app_rdy=1.
//    - Hold wren/end until sampled with app_wdf_rdy=1.
//    - The two acceptances are independent; either order or the same cycle.
//    - Data may be accepted before the command, per MIG rules.
//    - When both are done (read: command only): deassert, -> IDLE.
//    - Next grant earliest in the following cycle.
//    - Throughput: max 1 command / 2 clk.
//  Tag FIFO: push grant ID on app_en&app_rdy for reads; pop on app_rd_data_valid.
//    - Push and pop in the same cycle are legal.
//    - Occupancy does not change in that case.
//  Return path: 1-cycle latency.
//    - rsp_valid[head] = 1 and rsp_data = app_rd_data, the cycle after app_rd_data_valid.
//    - No backpressure: requesters reserve sink space before requesting.
//  app_rd_data_valid with tag FIFO empty: data dropped, err_unexpected_rd set until reset.
//  req_valid dropped by requester before req_ready: no grant; never a partial command.
//  RR pointer updates only on grant; a single active requester is granted back to back.
//  Reset mid-operation: command aborted, tags lost; later MIG returns raise err_unexpected_rd.
// STRUCTURE
//  Package ddr3_ui_pkg holds the shared constants:
//    - CMD_WRITE = 3'b000, CMD_READ = 3'b001
//    - UI_ADDR_W = 30, UI_DATA_W = 256
//    - BL8 address increment = 8
//  One sub-module: ddr3_rd_tag_fifo (sync FIFO of requester IDs; count, full, empty).
//  Arbiter FSM, RR logic and command/data registers stay in this file.
// TESTING
//  1. Req0 write addr 0x08, data A5..; app_rdy=app_wdf_rdy=1
//     -> req_ready[0] pulse; next clk app_en, cmd 000, addr 0x08, wren+end, data A5..; IDLE 1 clk later.
//  2. Req0 and req1 valid continuously (writes)
//     -> grants alternate 0,1,0,1; every command accepted exactly once.
//  3. Write, app_wdf_rdy=1 at clk 1, app_rdy held low 5 clk
//     -> wren drops after clk 1; app_en held 5 clk; single command issued.
//  4. Req1 reads 0x10, req0 reads 0x18; MIG returns D1, D0
//     -> rsp_valid[1] with D1, then rsp_valid[0] with D0; rd_outstanding 2->1->0.
//  5. 33 back-to-back reads, no returns (depth 32)
//     -> 32 accepted, 33rd blocked, writes still granted; one return unblocks it.
//  6. app_rd_data_valid with no reads pending
//     -> no rsp_valid, err_unexpected_rd=1 held; reset_n low clears it asynchronously.

Source files
------------

// File: rtl/ddr3_ui_pkg.sv
// Shared constants for the DDR3 MIG user-interface arbiter.
package ddr3_ui_pkg;

  typedef logic [2:0] app_cmd_t;

  localparam app_cmd_t CMD_WRITE    = 3'b000;
  localparam app_cmd_t CMD_READ     = 3'b001;
  localparam int       UI_ADDR_W    = 30;
  localparam int       UI_DATA_W    = 256;
  // One BL8 burst covers eight UI address units
  localparam int       BL8_ADDR_INC = 8;

endpackage

// File: rtl/ddr3_rd_tag_fifo.sv
// Synchronous FIFO of requester IDs for reads the MIG has accepted but not yet returned.
module ddr3_rd_tag_fifo #(
  parameter int ID_W  = 1,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [ID_W-1:0]          push_id,
  input  logic                     pop,
  output logic [ID_W-1:0]          head_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Tag storage: payload only, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_id = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/ddr3_ui_arbiter.sv
// Round-robin arbiter sharing one DDR3 MIG user interface between NUM_REQ requesters.
// One BL8 command per grant; read data is routed back to its requester in order.
module ddr3_ui_arbiter
  import ddr3_ui_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = UI_ADDR_W,
  parameter int DATA_W       = UI_DATA_W,
  parameter int RD_TAG_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_rnw,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [$clog2(RD_TAG_DEPTH):0] rd_outstanding,
  output logic                          err_unexpected_rd,
  input  logic                          app_rdy,
  output logic                          app_en,
  output logic [2:0]                    app_cmd,
  output logic [ADDR_W-1:0]             app_addr,
  input  logic                          app_wdf_rdy,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  output logic [DATA_W-1:0]             app_wdf_data,
  output logic [DATA_W/8-1:0]           app_wdf_mask,
  input  logic [DATA_W-1:0]             app_rd_data,
  input  logic                          app_rd_data_valid
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cap_id;
  logic               cap_rnw;
  logic [NUM_REQ-1:0] elig;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    gnt_next;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               cmd_done;
  logic               data_done;
  logic               tag_push;
  logic               tag_pop;
  logic [ID_W-1:0]    tag_head;
  logic               tag_full;
  logic               tag_empty;

  // Grants only happen in IDLE when nothing is in flight, so the FIFO count
  // already includes every reservation; a read needs one free slot.
  assign elig = req_valid & (~req_rnw | {NUM_REQ{~tag_full}});

  // Round-robin pick: first eligible requester at or after rr_ptr
  always_comb begin
    int idx;
    gnt_found  = 1'b0;
    gnt_id     = '0;
    gnt_onehot = '0;
    idx        = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (elig[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[ID_W-1:0];
      end
    end
    if (gnt_found) gnt_onehot[gnt_id] = 1'b1;
    gnt_next = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
  end

  assign req_ready    = (state == ST_IDLE) ? gnt_onehot : '0;
  assign cmd_done     = ~app_en | app_rdy;
  assign data_done    = ~app_wdf_wren | app_wdf_rdy;
  assign app_wdf_mask = '0;

  // Arbiter FSM: capture on grant, then hold command and data until each is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      cap_id       <= '0;
      cap_rnw      <= 1'b0;
      app_en       <= 1'b0;
      app_cmd      <= CMD_WRITE;
      app_addr     <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      app_wdf_data <= '0;
    end else if (state == ST_IDLE) begin
      if (gnt_found) begin
        state        <= ST_ISSUE;
        rr_ptr       <= gnt_next;
        cap_id       <= gnt_id;
        cap_rnw      <= req_rnw[gnt_id];
        app_en       <= 1'b1;
        app_cmd      <= req_rnw[gnt_id] ? CMD_READ : CMD_WRITE;
        app_addr     <= req_addr[gnt_id*ADDR_W +: ADDR_W];
        app_wdf_wren <= ~req_rnw[gnt_id];
        app_wdf_end  <= ~req_rnw[gnt_id];
        if (!req_rnw[gnt_id]) app_wdf_data <= req_wdata[gnt_id*DATA_W +: DATA_W];
      end
    end else begin
      if (app_rdy) app_en <= 1'b0;
      if (app_wdf_rdy) begin
        app_wdf_wren <= 1'b0;
        app_wdf_end  <= 1'b0;
      end
      if (cmd_done && data_done) state <= ST_IDLE;
    end
  end

  // Tag the read when the MIG accepts the command; retire the oldest tag per returned beat
  assign tag_push = app_en & app_rdy & cap_rnw;
  assign tag_pop  = app_rd_data_valid & ~tag_empty;

  ddr3_rd_tag_fifo #(
    .ID_W  (ID_W),
    .DEPTH (RD_TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tag_push),
    .push_id (cap_id),
    .pop     (tag_pop),
    .head_id (tag_head),
    .count   (rd_outstanding),
    .full    (tag_full),
    .empty   (tag_empty)
  );

  // Return path: one-cycle registered delivery; untagged data is dropped and flagged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid         <= '0;
      rsp_data          <= '0;
      err_unexpected_rd <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (tag_pop) begin
        rsp_valid[tag_head] <= 1'b1;
        rsp_data            <= app_rd_data;
      end
      if (app_rd_data_valid && tag_empty) err_unexpected_rd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_ui_arbiter.sv
// Bench for ddr3_ui_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_ddr3_ui_arbiter;
  import ddr3_ui_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 256;
  localparam int DEPTH   = 32;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_rnw = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [CNT_W-1:0]          rd_outstanding;
  logic                      err_unexpected_rd;
  logic                      app_rdy = 1'b0;
  logic                      app_en;
  logic [2:0]                app_cmd;
  logic [ADDR_W-1:0]         app_addr;
  logic                      app_wdf_rdy = 1'b0;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic [DATA_W-1:0]         app_wdf_data;
  logic [DATA_W/8-1:0]       app_wdf_mask;
  logic [DATA_W-1:0]         app_rd_data = '0;
  logic                      app_rd_data_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state: the one command in flight plus the queue of read owners
  bit                 m_busy, m_cp, m_dp, m_rnw, m_err;
  int                 m_id, m_rr;
  logic [ADDR_W-1:0]  m_addr;
  logic [DATA_W-1:0]  m_data;
  logic [NUM_REQ-1:0] m_rsp_v;
  logic [DATA_W-1:0]  m_rsp_d;
  int                 q[$];

  ddr3_ui_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TAG_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rd_outstanding(rd_outstanding), .err_unexpected_rd(err_unexpected_rd),
    .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int i, input logic v, input logic rnw,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid[i] = v;
    req_rnw[i]   = rnw;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Who should win: scan from the round-robin start for the first requester
  // that wants the bus and, for a read, has a free tag slot.
  function automatic int exp_grant();
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_rr + k) % NUM_REQ;
      if (req_valid[i] && (!req_rnw[i] || q.size() < DEPTH)) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_cp = 0; m_dp = 0; m_rnw = 0; m_err = 0;
    m_id = 0; m_rr = 0; m_rsp_v = '0; m_rsp_d = '0;
    q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0; req_rnw = '0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_app_en", app_en, 0);
    chk("rst_app_cmd", app_cmd, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_wend", app_wdf_end, 0);
    chk("rst_wdata", app_wdf_data, 0);
    chk("rst_mask", app_wdf_mask, 0);
    chk("rst_outstanding", rd_outstanding, 0);
    chk("rst_err", err_unexpected_rd, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One clock: check outputs against the model, then advance the model over the edge
  task automatic step();
    int g;
    int h;
    logic [NUM_REQ-1:0] exp_rdy;
    #1;
    g = m_busy ? -1 : exp_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("app_en", app_en, m_cp);
    if (m_cp) begin
      chk("app_cmd", app_cmd, m_rnw ? CMD_READ : CMD_WRITE);
      chk("app_addr", app_addr, m_addr);
    end
    chk("wdf_wren", app_wdf_wren, m_dp);
    chk("wdf_end", app_wdf_end, m_dp);
    if (m_dp) chk("wdf_data", app_wdf_data, m_data);
    chk("rsp_valid", rsp_valid, m_rsp_v);
    if (m_rsp_v != 0) chk("rsp_data", rsp_data, m_rsp_d);
    chk("rd_outstanding", rd_outstanding, q.size());
    chk("err_unexpected", err_unexpected_rd, m_err);

    m_rsp_v = '0;
    if (app_rd_data_valid) begin
      if (q.size() > 0) begin
        h = q.pop_front();
        m_rsp_v[h] = 1'b1;
        m_rsp_d = app_rd_data;
      end else begin
        m_err = 1;
      end
    end
    if (m_busy) begin
      if (m_cp && app_rdy) begin
        m_cp = 0;
        if (m_rnw) q.push_back(m_id);
      end
      if (m_dp && app_wdf_rdy) m_dp = 0;
      if (!m_cp && !m_dp) m_busy = 0;
    end else if (g >= 0) begin
      m_busy = 1; m_cp = 1; m_id = g; m_rnw = req_rnw[g]; m_dp = !req_rnw[g];
      m_addr = req_addr[g*ADDR_W +: ADDR_W];
      if (!req_rnw[g]) m_data = req_wdata[g*DATA_W +: DATA_W];
      m_rr = (g + 1) % NUM_REQ;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] d0, d1;
    #2;
    do_reset();

    // Single write from requester 0
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    set_req(0, 1'b1, 1'b0, 30'h8, {32{8'hA5}});
    step();
    req_valid = '0;
    chk("t1_app_en", app_en, 1);
    chk("t1_app_cmd", app_cmd, 3'b000);
    chk("t1_app_addr", app_addr, 30'h8);
    chk("t1_wdata", app_wdf_data, {32{8'hA5}});
    step();
    chk("t1_idle_en", app_en, 0);
    step();

    // Two continuous writers alternate
    set_req(0, 1'b1, 1'b0, 30'h100, rand256());
    set_req(1, 1'b1, 1'b0, 30'h200, rand256());
    repeat (10) step();
    req_valid = '0;
    repeat (2) step();

    // Data accepted first, command stalled five cycles
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    set_req(0, 1'b1, 1'b0, 30'h40, rand256());
    step();
    req_valid = '0;
    step();
    app_wdf_rdy = 1'b0;
    repeat (4) step();
    chk("t3_en_held", app_en, 1);
    chk("t3_wren_dropped", app_wdf_wren, 0);
    app_rdy = 1'b1;
    step();
    chk("t3_en_released", app_en, 0);
    step();

    // Two reads from different requesters returned in order
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    set_req(1, 1'b1, 1'b1, 30'h10, '0);
    step();
    req_valid = '0;
    step();
    set_req(0, 1'b1, 1'b1, 30'h18, '0);
    step();
    req_valid = '0;
    step();
    chk("t4_out2", rd_outstanding, 2);
    d1 = rand256(); d0 = rand256();
    app_rd_data_valid = 1'b1; app_rd_data = d1;
    step();
    chk("t4_out1", rd_outstanding, 1);
    chk("t4_rsp1", rsp_valid, 3'b010);
    chk("t4_rsp1_data", rsp_data, d1);
    app_rd_data = d0;
    step();
    app_rd_data_valid = 1'b0;
    chk("t4_out0", rd_outstanding, 0);
    chk("t4_rsp0", rsp_valid, 3'b001);
    chk("t4_rsp0_data", rsp_data, d0);
    step();

    // Fill the tag FIFO, confirm writes still pass, then free one slot
    set_req(0, 1'b1, 1'b1, 30'h1000, '0);
    repeat (70) step();
    chk("t5_full", rd_outstanding, DEPTH);
    set_req(1, 1'b1, 1'b0, 30'h2000, rand256());
    repeat (4) step();
    req_valid[1] = 1'b0;
    step();
    chk("t5_still_full", rd_outstanding, DEPTH);
    app_rd_data_valid = 1'b1; app_rd_data = rand256();
    step();
    app_rd_data_valid = 1'b0;
    repeat (4) step();
    chk("t5_refilled", rd_outstanding, DEPTH);
    req_valid = '0;
    step();
    while (q.size() > 0) begin
      app_rd_data_valid = 1'b1; app_rd_data = rand256();
      step();
    end
    app_rd_data_valid = 1'b0;
    step();

    // Read data with nothing outstanding
    app_rd_data_valid = 1'b1; app_rd_data = rand256();
    step();
    app_rd_data_valid = 1'b0;
    repeat (3) step();
    chk("t6_err_held", err_unexpected_rd, 1);
    chk("t6_no_rsp", rsp_valid, 0);
    do_reset();
    chk("t6_err_cleared", err_unexpected_rd, 0);

    // Randomized traffic, with one reset in the middle of operation
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        do_reset();
        app_rd_data_valid = 1'b1; app_rd_data = rand256();
        step();
        continue;
      end
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, ($urandom_range(0, 9) < 6), $urandom_range(0, 1),
                ADDR_W'($urandom) & ~ADDR_W'(BL8_ADDR_INC - 1), rand256());
      app_rdy           = ($urandom_range(0, 9) < 7);
      app_wdf_rdy       = ($urandom_range(0, 9) < 7);
      app_rd_data_valid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      app_rd_data       = rand256();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
